// File: rtl/endecrypt_pkg.sv
// rtl/endecrypt_pkg.sv - shared types and constants for the nibble encryptor/decryptor pair
package endecrypt_pkg;

  localparam int NIB_W = 4;

  localparam int              ROT_DEFAULT      = 1;
  localparam logic [NIB_W-1:0] KEY_STEP_DEFAULT = 4'h3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/nibble_cipher_step.sv
// rtl/nibble_cipher_step.sv - combinational cipher step: XOR, rotate-right, rolling key update
module nibble_cipher_step
  import endecrypt_pkg::*;
#(
  parameter int               ROT      = ROT_DEFAULT,
  parameter logic [NIB_W-1:0] KEY_STEP = KEY_STEP_DEFAULT
) (
  input  logic [NIB_W-1:0] key,
  input  logic [NIB_W-1:0] din,
  output logic [NIB_W-1:0] cipher,
  output logic [NIB_W-1:0] key_next
);

  logic [NIB_W-1:0] mix;
  logic [NIB_W-1:0] key_rotl;

  // Mixed nibble, then rotate right by ROT; ROT=0 makes the left shift drop out entirely.
  assign mix    = din ^ key;
  assign cipher = (mix >> ROT) | (mix << (NIB_W - ROT));

  // Rolling key: rotate left by one and add the step constant, wrapping at 4 bits.
  assign key_rotl = {key[NIB_W-2:0], key[NIB_W-1]};
  assign key_next = key_rotl + KEY_STEP;

endmodule

// File: rtl/nibble_decryptor.sv
// rtl/nibble_decryptor.sv - streaming nibble decryptor with rolling key and output backpressure
module nibble_decryptor
  import endecrypt_pkg::*;
#(
  parameter int               ROT      = ROT_DEFAULT,
  parameter logic [NIB_W-1:0] KEY_STEP = KEY_STEP_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [NIB_W-1:0] Key,
  input  logic [NIB_W-1:0] Len,
  input  logic [NIB_W-1:0] Din,
  input  logic             DinVld,
  output logic             DinRdy,
  output logic [NIB_W-1:0] Dout,
  output logic             DoutVld,
  input  logic             DoutRdy,
  output logic             Busy,
  output logic             Done
);

  state_t           state;
  logic [NIB_W-1:0] key_r;
  logic [NIB_W:0]   rem;
  logic [NIB_W-1:0] dout_r;
  logic             dout_vld_r;
  logic             done_r;

  logic [NIB_W-1:0] cipher;
  logic [NIB_W-1:0] key_next;

  nibble_cipher_step #(
    .ROT      (ROT),
    .KEY_STEP (KEY_STEP)
  ) u_step (
    .key      (key_r),
    .din      (Din),
    .cipher   (cipher),
    .key_next (key_next)
  );

  // Handshake flags decode straight from the state register so they drop with reset.
  assign DinRdy  = (state == ST_RUN);
  assign Busy    = (state != ST_IDLE);
  assign Dout    = dout_r;
  assign DoutVld = dout_vld_r;
  assign Done    = done_r;

  // Message FSM: accept one nibble, hold it until consumed, pulse Done after the last one.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= ST_IDLE;
      key_r      <= '0;
      rem        <= '0;
      dout_r     <= '0;
      dout_vld_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (Start) begin
            key_r <= Key;
            rem   <= (Len == '0) ? 5'd16 : {1'b0, Len};
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (DinVld) begin
            dout_r     <= cipher;
            dout_vld_r <= 1'b1;
            key_r      <= key_next;
            rem        <= rem - 5'd1;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (DoutRdy) begin
            dout_vld_r <= 1'b0;
            if (rem == '0) begin
              done_r <= 1'b1;
              state  <= ST_DONE;
            end else begin
              state  <= ST_RUN;
            end
          end
        end
        ST_DONE: begin
          done_r <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          done_r <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_decryptor.sv
// tb/tb_nibble_decryptor.sv - self-checking bench for nibble_decryptor
module tb_nibble_decryptor;

  localparam int ROT_M   = 1;
  localparam int KSTEP_M = 3;

  logic       CLK;
  logic       RST;
  logic       Start;
  logic [3:0] Key;
  logic [3:0] Len;
  logic [3:0] Din;
  logic       DinVld;
  logic       DinRdy;
  logic [3:0] Dout;
  logic       DoutVld;
  logic       DoutRdy;
  logic       Busy;
  logic       Done;

  int pass_cnt;
  int total_cnt;

  nibble_decryptor dut (
    .CLK     (CLK),
    .RST     (RST),
    .Start   (Start),
    .Key     (Key),
    .Len     (Len),
    .Din     (Din),
    .DinVld  (DinVld),
    .DinRdy  (DinRdy),
    .Dout    (Dout),
    .DoutVld (DoutVld),
    .DoutRdy (DoutRdy),
    .Busy    (Busy),
    .Done    (Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int ref_plain(int k, int c);
    int v;
    v = (k ^ c) % 16;
    return ((v / (1 << ROT_M)) + (v * (1 << (4 - ROT_M)))) % 16;
  endfunction

  function automatic int ref_next_key(int k);
    return ((k * 2) % 16 + (k / 8) + KSTEP_M) % 16;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_message(input int key, input int len, input logic [3:0] data[16],
                               input int stall_max, input bit gaps, input bit poke);
    int n;
    int k;
    int exp;
    int stall;
    n = (len == 0) ? 16 : len;
    k = key;
    Start = 1'b1;
    Key   = 4'(key);
    Len   = 4'(len);
    tick();
    Start = 1'b0;
    total_cnt++;
    if (Busy !== 1'b1 || DinRdy !== 1'b1) $display("FAIL start_run: Busy=%b DinRdy=%b want 1/1", Busy, DinRdy);
    else pass_cnt++;
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        DinVld = 1'b0;
        Din    = 4'($urandom);
        Start  = poke;
        Key    = 4'(~key);
        Len    = 4'($urandom);
        tick();
        Start = 1'b0;
        total_cnt++;
        if (DinRdy !== 1'b1 || DoutVld !== 1'b0 || Done !== 1'b0)
          $display("FAIL run_idle: DinRdy=%b DoutVld=%b Done=%b want 1/0/0", DinRdy, DoutVld, Done);
        else pass_cnt++;
      end
      exp    = ref_plain(k, int'(data[i]));
      k      = ref_next_key(k);
      Din    = data[i];
      DinVld = 1'b1;
      tick();
      DinVld = 1'b0;
      total_cnt++;
      if (DoutVld !== 1'b1 || Dout !== 4'(exp) || DinRdy !== 1'b0)
        $display("FAIL out_nib%0d: Dout=%h DoutVld=%b DinRdy=%b want %h/1/0", i, Dout, DoutVld, DinRdy, exp);
      else pass_cnt++;
      stall = $urandom_range(0, stall_max);
      for (int s = 0; s < stall; s++) begin
        DoutRdy = 1'b0;
        Start   = poke;
        Key     = 4'(~key);
        tick();
        Start = 1'b0;
        total_cnt++;
        if (DoutVld !== 1'b1 || Dout !== 4'(exp) || DinRdy !== 1'b0 || Done !== 1'b0)
          $display("FAIL hold_stable: Dout=%h DoutVld=%b DinRdy=%b Done=%b want %h/1/0/0", Dout, DoutVld, DinRdy, Done, exp);
        else pass_cnt++;
      end
      DoutRdy = 1'b1;
      tick();
      DoutRdy = 1'b0;
      total_cnt++;
      if (i == n - 1) begin
        if (Done !== 1'b1 || DoutVld !== 1'b0 || Dout !== 4'(exp) || DinRdy !== 1'b0)
          $display("FAIL done_pulse: Done=%b DoutVld=%b Dout=%h DinRdy=%b want 1/0/%h/0", Done, DoutVld, Dout, DinRdy, exp);
        else pass_cnt++;
      end else begin
        if (Done !== 1'b0 || DoutVld !== 1'b0 || DinRdy !== 1'b1 || Dout !== 4'(exp))
          $display("FAIL after_ack: Done=%b DoutVld=%b DinRdy=%b Dout=%h want 0/0/1/%h", Done, DoutVld, DinRdy, Dout, exp);
        else pass_cnt++;
      end
    end
    Start = poke;
    Key   = 4'(~key);
    tick();
    Start = 1'b0;
    total_cnt++;
    if (Done !== 1'b0 || Busy !== 1'b0 || DinRdy !== 1'b0)
      $display("FAIL idle_after: Done=%b Busy=%b DinRdy=%b want 0/0/0", Done, Busy, DinRdy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    Start = 1'b0; Key = '0; Len = '0; Din = '0; DinVld = 1'b0; DoutRdy = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (Busy !== 1'b0 || DinRdy !== 1'b0 || DoutVld !== 1'b0 || Dout !== 4'h0 || Done !== 1'b0)
      $display("FAIL reset_state: Busy=%b DinRdy=%b DoutVld=%b Dout=%h Done=%b want all 0", Busy, DinRdy, DoutVld, Dout, Done);
    else pass_cnt++;
    RST = 1'b1;
    tick();
    total_cnt++;
    if (Busy !== 1'b0 || DinRdy !== 1'b0) $display("FAIL idle_hold: Busy=%b DinRdy=%b want 0/0", Busy, DinRdy);
    else pass_cnt++;
  endtask

  task automatic test_single();
    logic [3:0] d[16];
    foreach (d[i]) d[i] = '0;
    d[0] = 4'h5;
    drive_message(4'hA, 1, d, 0, 1'b0, 1'b0);
  endtask

  task automatic test_rolling_key();
    logic [3:0] d[16];
    foreach (d[i]) d[i] = '0;
    d[0] = 4'h5;
    d[1] = 4'h8;
    drive_message(4'hA, 2, d, 1, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [3:0] d[16];
    foreach (d[i]) d[i] = 4'($urandom);
    drive_message(int'($urandom_range(0, 15)), 3, d, 5, 1'b1, 1'b0);
  endtask

  task automatic test_len_zero();
    logic [3:0] d[16];
    foreach (d[i]) d[i] = 4'($urandom);
    drive_message(0, 0, d, 1, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    logic [3:0] d[16];
    foreach (d[i]) d[i] = 4'($urandom);
    drive_message(int'($urandom_range(0, 15)), 4, d, 2, 1'b1, 1'b1);
  endtask

  task automatic test_reset_in_hold();
    Start = 1'b1; Key = 4'h6; Len = 4'h3;
    tick();
    Start = 1'b0;
    Din = 4'h9; DinVld = 1'b1;
    tick();
    DinVld = 1'b0;
    total_cnt++;
    if (DoutVld !== 1'b1 || Dout !== 4'(ref_plain(6, 9)))
      $display("FAIL pre_reset_hold: DoutVld=%b Dout=%h want 1/%h", DoutVld, Dout, ref_plain(6, 9));
    else pass_cnt++;
    RST = 1'b0;
    tick();
    RST = 1'b1;
    total_cnt++;
    if (DoutVld !== 1'b0 || Dout !== 4'h0 || Busy !== 1'b0 || DinRdy !== 1'b0 || Done !== 1'b0)
      $display("FAIL reset_hold: DoutVld=%b Dout=%h Busy=%b DinRdy=%b Done=%b want 0/0/0/0/0", DoutVld, Dout, Busy, DinRdy, Done);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_random();
    logic [3:0] d[16];
    for (int m = 0; m < 20; m++) begin
      foreach (d[i]) d[i] = 4'($urandom);
      drive_message(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), d, 3, 1'b1, m[0]);
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_single();
    test_rolling_key();
    test_backpressure();
    test_len_zero();
    test_start_ignored();
    test_reset_in_hold();
    test_single();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
